// File: rtl/ex_mem_preloader.sv
// Streams a 32-bit program/data image into the core's external-memory load
// port. It packs words into two-word instruction plus two-word data beats,
// zero-pads the image up to NUM_BEATS beats, then pulses core reset and
// releases the core.
module ex_mem_preloader #(
    parameter int NUM_BEATS  = 32,
    parameter int ADDR_W     = 9,
    parameter int ADDR_STEP  = 8,
    parameter int RST_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              enable_load_ex_mem,
    output logic [ADDR_W-1:0] InstExMemAddress,
    output logic [31:0]       InstExMemData1,
    output logic [31:0]       InstExMemData2,
    output logic [ADDR_W-1:0] DataExMemAddress,
    output logic [31:0]       DataExMemData1,
    output logic [31:0]       DataExMemData2,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int BW = $clog2(NUM_BEATS + 1);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, FILL, WRITE, PAD, CORE_RST, RUN} stateT;

    stateT             stateReg, stateNext;
    logic [31:0]       slotBuf [4];
    logic [31:0]       beatWord [4];
    logic [31:0]       pinData [4];
    logic [1:0]        slotCnt;
    logic [BW-1:0]     beatCnt;
    logic [ADDR_W-1:0] addrReg;
    logic [ADDR_W-1:0] pinAddr;
    logic [ADDR_W-1:0] addrStep;
    logic [RW-1:0]     rstCnt;
    logic              lastSeen;
    logic              overflowReg;
    logic              accept;
    logic              beatDone;
    logic              lastBeat;
    logic              rstDone;

    // The FILL state is the only one that accepts words, so the handshake
    // reduces to in_valid while filling.
    assign accept   = (stateReg == FILL) && in_valid;
    assign beatDone = accept && ((slotCnt == 2'd3) || in_last);
    assign lastBeat = (beatCnt == BW'(NUM_BEATS - 1));
    assign rstDone  = (rstCnt == RW'(RST_CYCLES - 1));
    assign addrStep = addrReg + ADDR_W'(ADDR_STEP);

    // Beat as it would look if the word now on in_data closes it: earlier
    // slots come from the buffer, later slots are zero-filled.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gBeatWord
            localparam logic [1:0] SLOT = 2'(gi);
            assign beatWord[gi] = (SLOT < slotCnt)  ? slotBuf[gi] :
                                  (SLOT == slotCnt) ? in_data     : 32'd0;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (reset) stateReg <= IDLE;
        else       stateReg <= stateNext;
    end

    // Next-state logic.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE, RUN: if (start) stateNext = FILL;
            FILL:      if (beatDone) stateNext = WRITE;
            WRITE:     stateNext = lastBeat ? CORE_RST : (lastSeen ? PAD : FILL);
            PAD:       if (lastBeat) stateNext = CORE_RST;
            CORE_RST:  if (rstDone) stateNext = RUN;
            default:   stateNext = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        in_ready           = 1'b0;
        enable_load_ex_mem = 1'b0;
        core_reset         = 1'b0;
        busy               = 1'b0;
        done               = 1'b0;
        case (stateReg)
            IDLE:     core_reset = 1'b1;
            FILL:     begin in_ready = 1'b1; busy = 1'b1; end
            WRITE:    begin enable_load_ex_mem = 1'b1; busy = 1'b1; end
            PAD:      begin enable_load_ex_mem = 1'b1; busy = 1'b1; end
            CORE_RST: begin core_reset = 1'b1; busy = 1'b1; end
            RUN:      done = 1'b1;
            default:  core_reset = 1'b1;
        endcase
    end

    // Datapath: slot buffer, counters, and the pin registers that hold the
    // beat presented during each strobe (and keep it afterwards).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                slotBuf[i] <= 32'd0;
                pinData[i] <= 32'd0;
            end
            slotCnt     <= 2'd0;
            beatCnt     <= '0;
            addrReg     <= '0;
            pinAddr     <= '0;
            rstCnt      <= '0;
            lastSeen    <= 1'b0;
            overflowReg <= 1'b0;
        end else begin
            case (stateReg)
                IDLE, RUN: begin
                    if (start) begin
                        addrReg     <= '0;
                        beatCnt     <= '0;
                        slotCnt     <= 2'd0;
                        lastSeen    <= 1'b0;
                        overflowReg <= 1'b0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        slotBuf[slotCnt] <= in_data;
                        slotCnt          <= slotCnt + 2'd1;
                        if (in_last) lastSeen <= 1'b1;
                    end
                    if (beatDone) begin
                        pinAddr <= addrReg;
                        for (int i = 0; i < 4; i++) pinData[i] <= beatWord[i];
                    end
                end
                WRITE: begin
                    addrReg <= addrStep;
                    beatCnt <= beatCnt + BW'(1);
                    slotCnt <= 2'd0;
                    rstCnt  <= '0;
                    if (lastBeat && !lastSeen) overflowReg <= 1'b1;
                    // Entering PAD: present the first all-zero beat.
                    if (!lastBeat && lastSeen) begin
                        pinAddr <= addrStep;
                        for (int i = 0; i < 4; i++) pinData[i] <= 32'd0;
                    end
                end
                PAD: begin
                    addrReg <= addrStep;
                    beatCnt <= beatCnt + BW'(1);
                    rstCnt  <= '0;
                    if (!lastBeat) pinAddr <= addrStep;
                end
                CORE_RST: rstCnt <= rstCnt + RW'(1);
                default: ;
            endcase
        end
    end

    assign InstExMemAddress = pinAddr;
    assign DataExMemAddress = pinAddr;
    assign InstExMemData1   = pinData[0];
    assign InstExMemData2   = pinData[1];
    assign DataExMemData1   = pinData[2];
    assign DataExMemData2   = pinData[3];
    assign overflow         = overflowReg;

endmodule
